// File: rtl/acorn_process_if.sv
// rtl/acorn_process_if.sv - ACORN-128 processing-stage load, AD/PT input and CT/status output bundle
interface acorn_process_if;
  logic         init_valid;
  logic [292:0] init_state;
  logic         ad_empty;
  logic         pt_empty;
  logic         ad_valid;
  logic         ad_bit;
  logic         ad_last;
  logic         ad_ready;
  logic         pt_valid;
  logic         pt_bit;
  logic         pt_last;
  logic         pt_ready;
  logic         ct_valid;
  logic         ct_bit;
  logic         busy;
  logic         done;
  logic [292:0] state_out;

  modport master (
    output init_valid, init_state, ad_empty, pt_empty,
    output ad_valid, ad_bit, ad_last, pt_valid, pt_bit, pt_last,
    input  ad_ready, pt_ready, ct_valid, ct_bit, busy, done, state_out
  );

  modport slave (
    input  init_valid, init_state, ad_empty, pt_empty,
    input  ad_valid, ad_bit, ad_last, pt_valid, pt_bit, pt_last,
    output ad_ready, pt_ready, ct_valid, ct_bit, busy, done, state_out
  );
endinterface

// File: rtl/acorn_process.sv
// rtl/acorn_process.sv - ACORN-128 AD absorb, padding and bitwise PT encryption, one step per cycle
module acorn_process #(
  parameter int PAD_LEN = 256
) (
  input  logic             clk,
  input  logic             rst,
  acorn_process_if.slave   io
);

  localparam logic [7:0] CNT_LAST = 8'(PAD_LEN - 1);

  typedef enum logic [2:0] {IDLE, AD, AD_PAD, PT, PT_PAD, DONE} state_t;

  state_t       st, st_nxt;
  logic [292:0] s, s_nxt, t, s_step;
  logic [7:0]   cnt, cnt_nxt;
  logic         pt_empty_q, pt_empty_nxt;
  logic         ct_valid_q, ct_valid_nxt;
  logic         ct_bit_q, ct_bit_nxt;
  logic         m, ca, cb, ks, fb;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic ch3(input logic a, input logic b, input logic c);
    return (a & b) ^ (~a & c);
  endfunction

  // Step inputs depend only on the phase, so they are decoded apart from the next-state logic.
  always_comb begin
    m  = 1'b0;
    ca = 1'b0;
    cb = 1'b0;
    case (st)
      AD:      begin m = io.ad_bit;     ca = 1'b1;             cb = 1'b1; end
      AD_PAD:  begin m = (cnt == 8'd0); ca = (cnt < 8'd128);   cb = 1'b1; end
      PT:      begin m = io.pt_bit;     ca = 1'b1;             cb = 1'b0; end
      PT_PAD:  begin m = (cnt == 8'd0); ca = (cnt < 8'd128);   cb = 1'b0; end
      default: ;
    endcase
  end

  // The six LFSR feedback taps all read the unmodified state, so they can be applied in parallel.
  always_comb begin
    t      = s;
    t[289] = s[289] ^ s[235] ^ s[230];
    t[230] = s[230] ^ s[196] ^ s[193];
    t[193] = s[193] ^ s[160] ^ s[154];
    t[154] = s[154] ^ s[111] ^ s[107];
    t[107] = s[107] ^ s[66]  ^ s[61];
    t[61]  = s[61]  ^ s[23]  ^ s[0];
    ks     = t[12] ^ t[154] ^ maj3(t[235], t[61], t[193]) ^ ch3(t[230], t[111], t[66]);
    fb     = t[0] ^ ~t[107] ^ maj3(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
    s_step = {fb ^ m, t[292:1]};
  end

  always_comb begin
    st_nxt       = st;
    s_nxt        = s;
    cnt_nxt      = cnt;
    pt_empty_nxt = pt_empty_q;
    ct_valid_nxt = 1'b0;
    ct_bit_nxt   = 1'b0;
    case (st)
      IDLE, DONE: begin
        if (io.init_valid) begin
          s_nxt        = io.init_state;
          cnt_nxt      = 8'd0;
          pt_empty_nxt = io.pt_empty;
          st_nxt       = io.ad_empty ? AD_PAD : AD;
        end
      end
      AD: begin
        if (io.ad_valid) begin
          s_nxt = s_step;
          if (io.ad_last) begin
            st_nxt  = AD_PAD;
            cnt_nxt = 8'd0;
          end
        end
      end
      AD_PAD: begin
        s_nxt   = s_step;
        cnt_nxt = cnt + 8'd1;
        if (cnt == CNT_LAST) begin
          cnt_nxt = 8'd0;
          st_nxt  = pt_empty_q ? PT_PAD : PT;
        end
      end
      PT: begin
        if (io.pt_valid) begin
          s_nxt        = s_step;
          ct_valid_nxt = 1'b1;
          ct_bit_nxt   = io.pt_bit ^ ks;
          if (io.pt_last) begin
            st_nxt  = PT_PAD;
            cnt_nxt = 8'd0;
          end
        end
      end
      PT_PAD: begin
        s_nxt   = s_step;
        cnt_nxt = cnt + 8'd1;
        if (cnt == CNT_LAST) begin
          cnt_nxt = 8'd0;
          st_nxt  = DONE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      s          <= '0;
      cnt        <= 8'd0;
      pt_empty_q <= 1'b0;
      ct_valid_q <= 1'b0;
      ct_bit_q   <= 1'b0;
    end else begin
      st         <= st_nxt;
      s          <= s_nxt;
      cnt        <= cnt_nxt;
      pt_empty_q <= pt_empty_nxt;
      ct_valid_q <= ct_valid_nxt;
      ct_bit_q   <= ct_bit_nxt;
    end
  end

  assign io.ad_ready  = (st == AD);
  assign io.pt_ready  = (st == PT);
  assign io.busy      = (st != IDLE) && (st != DONE);
  assign io.done      = (st == DONE);
  assign io.ct_valid  = ct_valid_q;
  assign io.ct_bit    = ct_bit_q;
  assign io.state_out = s;

endmodule

// File: tb/tb_acorn_process.sv
// tb/tb_acorn_process.sv - directed self-checking bench for acorn_process against an ACORN-128 reference
module tb_acorn_process;

  logic clk = 1'b0;
  logic rst = 1'b0;
  acorn_process_if bus();

  acorn_process #(.PAD_LEN(256)) dut (.clk(clk), .rst(rst), .io(bus.slave));

  always #5 clk = ~clk;

  int   checks = 0;
  int   passed = 0;
  int   ct_seen = 0;
  logic exp_ct[$];
  logic ad_bits [0:63];
  logic pt_bits [0:63];

  task automatic chk(input string name, input logic [293:0] act, input logic [293:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic chs(input logic a, input logic b, input logic c);
    return (a & b) ^ (~a & c);
  endfunction

  // Reference StateUpdate128 written like the cipher's C code: in-place taps, then a bitwise shift.
  function automatic logic [293:0] ref_step(input logic [292:0] s, input logic m, input logic ca, input logic cb);
    logic [292:0] x;
    logic ks, f;
    x = s;
    x[289] ^= x[235] ^ x[230];
    x[230] ^= x[196] ^ x[193];
    x[193] ^= x[160] ^ x[154];
    x[154] ^= x[111] ^ x[107];
    x[107] ^= x[66] ^ x[61];
    x[61]  ^= x[23] ^ x[0];
    ks = x[12] ^ x[154] ^ maj(x[235], x[61], x[193]) ^ chs(x[230], x[111], x[66]);
    f  = x[0] ^ ~x[107] ^ maj(x[244], x[23], x[160]) ^ (ca & x[196]) ^ (cb & ks);
    for (int j = 0; j < 292; j++) x[j] = x[j+1];
    x[292] = f ^ m;
    return {ks, x};
  endfunction

  task automatic model(input logic [292:0] init, input int ad_len, input int pt_len, output logic [292:0] fin);
    logic [292:0] s;
    logic [293:0] r;
    s = init;
    for (int i = 0; i < ad_len; i++) begin r = ref_step(s, ad_bits[i], 1'b1, 1'b1); s = r[292:0]; end
    for (int i = 0; i < 256; i++) begin r = ref_step(s, i == 0, i < 128, 1'b1); s = r[292:0]; end
    for (int i = 0; i < pt_len; i++) begin
      r = ref_step(s, pt_bits[i], 1'b1, 1'b0);
      exp_ct.push_back(pt_bits[i] ^ r[293]);
      s = r[292:0];
    end
    for (int i = 0; i < 256; i++) begin r = ref_step(s, i == 0, i < 128, 1'b0); s = r[292:0]; end
    fin = s;
  endtask

  function automatic logic [292:0] rand_state();
    logic [292:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) v = {v[260:0], $urandom()};
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst && bus.ct_valid) begin
      ct_seen++;
      chk("ct_expected", 294'(exp_ct.size() != 0), 294'd1);
      if (exp_ct.size() != 0) chk("ct_bit", 294'(bus.ct_bit), 294'(exp_ct.pop_front()));
    end
  end

  task automatic run(input logic [292:0] init, input int ad_len, input int pt_len, input bit stall,
                     input bit inj, input int abort_at,
                     output logic [292:0] fin, output int done_at, output int busy_cnt);
    int ai, pi;
    bit hold_pend;
    logic [292:0] saved;
    ai = 0; pi = 0; done_at = -1; busy_cnt = 0; hold_pend = 1'b0; saved = '0; fin = '0;
    @(negedge clk);
    bus.init_valid = 1'b1;
    bus.init_state = init;
    bus.ad_empty   = (ad_len == 0);
    bus.pt_empty   = (pt_len == 0);
    @(negedge clk);
    for (int k = 0; k < 3000; k++) begin
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        chk("rst_outs", 294'({bus.ad_ready, bus.pt_ready, bus.ct_valid, bus.ct_bit, bus.busy, bus.done}), 294'd0);
        chk("rst_state", 294'(bus.state_out), 294'd0);
        @(negedge clk);
        chk("rst_held_busy", 294'(bus.busy), 294'd0);
        rst = 1'b1;
        break;
      end
      if (hold_pend) chk("stall_hold", 294'(bus.state_out), 294'(saved));
      hold_pend = 1'b0;
      if (bus.done) begin
        done_at = k;
        fin = bus.state_out;
        break;
      end
      if (bus.busy) busy_cnt++;
      bus.init_valid = 1'b0;
      bus.init_state = rand_state();
      bus.ad_empty = 1'($urandom()); bus.pt_empty = 1'($urandom());
      bus.ad_valid = 1'($urandom()); bus.ad_bit = 1'($urandom()); bus.ad_last = 1'($urandom());
      bus.pt_valid = 1'($urandom()); bus.pt_bit = 1'($urandom()); bus.pt_last = 1'($urandom());
      if (bus.ad_ready && ai < ad_len) begin
        if (stall && (k % 2 == 1)) begin
          bus.ad_valid = 1'b0;
          hold_pend = 1'b1;
          saved = bus.state_out;
        end else begin
          bus.ad_valid = 1'b1;
          bus.ad_bit = ad_bits[ai];
          bus.ad_last = (ai == ad_len - 1);
          ai++;
        end
      end
      if (bus.pt_ready && pi < pt_len) begin
        bus.pt_valid = 1'b1;
        bus.pt_bit = pt_bits[pi];
        bus.pt_last = (pi == pt_len - 1);
        if (inj && pi == 3) bus.init_valid = 1'b1;
        pi++;
      end
      @(negedge clk);
    end
    bus.init_valid = 1'b0;
    bus.ad_valid = 1'b0;
    bus.pt_valid = 1'b0;
  endtask

  initial begin
    logic [292:0] init_a, init_b, exp_fin, golden, fin;
    int done_at, busy_cnt;
    bus.init_valid = 1'b0; bus.init_state = '0; bus.ad_empty = 1'b0; bus.pt_empty = 1'b0;
    bus.ad_valid = 1'b0; bus.ad_bit = 1'b0; bus.ad_last = 1'b0;
    bus.pt_valid = 1'b0; bus.pt_bit = 1'b0; bus.pt_last = 1'b0;
    for (int i = 0; i < 64; i++) begin ad_bits[i] = 1'($urandom()); pt_bits[i] = 1'($urandom()); end
    init_a = rand_state();
    init_b = rand_state();

    // Hand-derived single steps that pin the reference model.
    chk("pin_zero", ref_step('0, 1'b0, 1'b0, 1'b0), {1'b0, 1'b1, 292'd0});
    chk("pin_m1",   ref_step('0, 1'b1, 1'b0, 1'b0), 294'd0);
    chk("pin_b12",  ref_step(293'd1 << 12, 1'b0, 1'b0, 1'b1), {1'b1, 293'd1 << 11});
    chk("pin_b0",   ref_step(293'd1, 1'b0, 1'b0, 1'b0), {1'b0, 293'd1 << 60});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 294'({bus.ad_ready, bus.pt_ready, bus.ct_valid, bus.ct_bit, bus.busy, bus.done}), 294'd0);
    chk("reset_state", 294'(bus.state_out), 294'd0);
    @(negedge clk);
    rst = 1'b1;

    // Empty AD and PT: padding only.
    ct_seen = 0;
    model(init_a, 0, 0, exp_fin);
    run(init_a, 0, 0, 1'b0, 1'b0, -1, fin, done_at, busy_cnt);
    chk("empty_done_at", 294'(done_at), 294'd512);
    chk("empty_busy", 294'(busy_cnt), 294'd512);
    chk("empty_state", 294'(fin), 294'(exp_fin));
    chk("empty_ct", 294'(ct_seen), 294'd0);

    // 8 AD bits, 16 PT bits, streams valid every cycle.
    ct_seen = 0;
    model(init_b, 8, 16, exp_fin);
    run(init_b, 8, 16, 1'b0, 1'b0, -1, golden, done_at, busy_cnt);
    chk("main_done_at", 294'(done_at), 294'd536);
    chk("main_state", 294'(golden), 294'(exp_fin));
    chk("main_ct_count", 294'(ct_seen), 294'd16);
    chk("main_ct_left", 294'(exp_ct.size()), 294'd0);

    // AD valid toggling: every other AD cycle is a stall.
    ct_seen = 0;
    model(init_b, 8, 16, exp_fin);
    run(init_b, 8, 16, 1'b1, 1'b0, -1, fin, done_at, busy_cnt);
    chk("stall_done_at", 294'(done_at), 294'd543);
    chk("stall_state", 294'(fin), 294'(golden));
    chk("stall_ct_count", 294'(ct_seen), 294'd16);

    // Reset at cnt=100 of AD_PAD, then a clean rerun.
    exp_ct.delete();
    run(init_b, 8, 16, 1'b0, 1'b0, 108, fin, done_at, busy_cnt);
    exp_ct.delete();
    @(negedge clk);
    chk("post_rst_idle", 294'({bus.ad_ready, bus.pt_ready, bus.ct_valid, bus.busy, bus.done}), 294'd0);
    ct_seen = 0;
    model(init_b, 8, 16, exp_fin);
    run(init_b, 8, 16, 1'b0, 1'b0, -1, fin, done_at, busy_cnt);
    chk("rerun_done_at", 294'(done_at), 294'd536);
    chk("rerun_state", 294'(fin), 294'(golden));

    // Stray init_valid during PT is ignored.
    ct_seen = 0;
    model(init_b, 8, 16, exp_fin);
    run(init_b, 8, 16, 1'b0, 1'b1, -1, fin, done_at, busy_cnt);
    chk("inj_done_at", 294'(done_at), 294'd536);
    chk("inj_state", 294'(fin), 294'(golden));
    chk("inj_ct_count", 294'(ct_seen), 294'd16);

    // Single AD bit, then 4 PT bits; loaded from DONE.
    ct_seen = 0;
    model(init_a, 1, 4, exp_fin);
    run(init_a, 1, 4, 1'b0, 1'b0, -1, fin, done_at, busy_cnt);
    chk("one_done_at", 294'(done_at), 294'd517);
    chk("one_state", 294'(fin), 294'(exp_fin));
    chk("one_ct_count", 294'(ct_seen), 294'd4);
    chk("one_ct_left", 294'(exp_ct.size()), 294'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
